// File: rtl/score_update_scheduler.sv
// Round-robin arbiter for point awards feeding a saturating pending accumulator.
// The accumulator drains into the BCD score counter as single-cycle enable pulses paced by counterReady.
module score_update_scheduler #(
    parameter int NUM_SOURCES   = 4,
    parameter int POINTS_WIDTH  = 4,
    parameter int PENDING_WIDTH = 8
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [NUM_SOURCES-1:0]              sourceRequest,
    input  logic [NUM_SOURCES*POINTS_WIDTH-1:0] sourcePoints,
    output logic [NUM_SOURCES-1:0]              sourceGrant,
    input  logic                                counterReady,
    output logic                                counterEnable,
    output logic [PENDING_WIDTH-1:0]            pendingCount,
    output logic                                busy,
    output logic                                overflow,
    output logic [1:0]                          drainState
);

    // Handshakes:
    //   A requester holds sourceRequest[i] high until it sees sourceGrant[i].
    //   sourceGrant[i] is high for exactly one cycle, and the award is sampled when the grant is decided.
    //   A request that is still high in the grant-visible cycle is masked for that cycle.
    //   counterEnable is a single-cycle pulse. It is issued only after counterReady was seen high.
    localparam int IDX_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
    localparam int SUM_W = PENDING_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2,
        WAIT  = 2'd3
    } drain_state_t;

    drain_state_t state;
    drain_state_t state_next;

    logic [IDX_W-1:0]        rr_ptr;
    logic [IDX_W-1:0]        ptr_next;
    logic [IDX_W-1:0]        cand_idx;
    logic [NUM_SOURCES-1:0]  eligible;
    logic [NUM_SOURCES-1:0]  grant_next;
    logic                    grant_found;
    logic [POINTS_WIDTH-1:0] award_points;
    logic [POINTS_WIDTH-1:0] pts_arr [NUM_SOURCES];
    logic [SUM_W-1:0]        sum_wide;
    logic                    pending_nz;

    always_comb begin
        for (int i = 0; i < NUM_SOURCES; i++) begin
            pts_arr[i] = sourcePoints[i*POINTS_WIDTH +: POINTS_WIDTH];
        end
    end

    // Search starts at the pointer and wraps. The first eligible requester wins.
    always_comb begin
        eligible     = sourceRequest & ~sourceGrant;
        grant_found  = 1'b0;
        grant_next   = '0;
        award_points = '0;
        ptr_next     = rr_ptr;
        cand_idx     = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            cand_idx = IDX_W'((int'(rr_ptr) + i) % NUM_SOURCES);
            if (!grant_found && eligible[cand_idx]) begin
                grant_found          = 1'b1;
                grant_next[cand_idx] = 1'b1;
                award_points         = pts_arr[cand_idx];
                ptr_next             = IDX_W'((int'(cand_idx) + 1) % NUM_SOURCES);
            end
        end
    end

    assign pending_nz = (pendingCount != '0);

    // One spare bit holds the worst case pending + award. If that bit is set, the total has saturated.
    assign sum_wide = SUM_W'(pendingCount) + SUM_W'(award_points) - SUM_W'(counterEnable);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sourceGrant  <= '0;
            rr_ptr       <= '0;
            pendingCount <= '0;
            overflow     <= 1'b0;
        end else begin
            sourceGrant <= grant_next;
            if (grant_found) begin
                rr_ptr <= ptr_next;
            end
            if (sum_wide[PENDING_WIDTH]) begin
                pendingCount <= '1;
                overflow     <= 1'b1;
            end else begin
                pendingCount <= sum_wide[PENDING_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // HOLD covers the counter's ready-drop latency. counterReady is not trusted until WAIT.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pending_nz && counterReady) begin
                    state_next = PULSE;
                end
            end
            PULSE: state_next = HOLD;
            HOLD:  state_next = WAIT;
            WAIT: begin
                if (counterReady) begin
                    state_next = pending_nz ? PULSE : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign counterEnable = (state == PULSE);
    assign busy          = (state != IDLE) || pending_nz;
    assign drainState    = state;

endmodule
